// File: rtl/peripheral_biu_initiator.sv
// Single-transfer BIU bus initiator: one command in, one strobe/address/data transfer out,
// one response back. A watchdog turns a hung transfer into an error response.
module peripheral_biu_initiator #(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [PLEN-1:0] cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [2:0]      cmd_prot,
    input  logic            cmd_lock,
    input  logic [XLEN-1:0] cmd_data,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_q,
    output logic            rsp_err,
    output logic            rsp_timeout,

    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    output logic [PLEN-1:0] biu_adri_o,
    input  logic [PLEN-1:0] biu_adro_i,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // TIMEOUT of 0 disables the watchdog; keep the counter at least one bit wide.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         state, state_nxt;
    logic [WDW-1:0] wd_cnt;
    logic           busy, done, tmo, accept;

    logic unused_inputs;
    assign unused_inputs = ^{biu_adro_i, biu_d_ack_i};

    always_comb begin
        busy   = (state == REQ) || (state == WAIT);
        done   = ((state == REQ) && biu_stb_ack_i && (biu_ack_i || biu_err_i)) ||
                 ((state == WAIT) && (biu_ack_i || biu_err_i));
        tmo    = busy && !done && (TIMEOUT > 0) && (wd_cnt == WD_LAST);
        accept = cmd_valid && cmd_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (done || tmo)        state_nxt = RESP;
                else if (biu_stb_ack_i) state_nxt = WAIT;
            end
            WAIT: if (done || tmo) state_nxt = RESP;
            RESP: if (rsp_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE) && !rst;
        rsp_valid  = (state == RESP);
        biu_stb_o  = (state == REQ);
        biu_type_o = 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            biu_adri_o  <= '0;
            biu_size_o  <= '0;
            biu_prot_o  <= '0;
            biu_lock_o  <= 1'b0;
            biu_we_o    <= 1'b0;
            biu_d_o     <= '0;
            wd_cnt      <= '0;
            rsp_q       <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                biu_adri_o <= cmd_addr;
                biu_size_o <= cmd_size;
                biu_prot_o <= cmd_prot;
                biu_lock_o <= cmd_lock;
                biu_we_o   <= cmd_we;
                biu_d_o    <= cmd_data;
                wd_cnt     <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end

            // Completion beats a same-cycle timeout; ack+err together is an error.
            if (done) begin
                rsp_q       <= (biu_err_i || biu_we_o) ? '0 : biu_q_i;
                rsp_err     <= biu_err_i;
                rsp_timeout <= 1'b0;
            end else if (tmo) begin
                rsp_q       <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_biu_initiator.sv
// Directed bench for peripheral_biu_initiator with the watchdog shortened to 8 cycles.
module tb_peripheral_biu_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we, cmd_lock;
    logic [63:0] cmd_addr, cmd_data;
    logic [2:0]  cmd_size, cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [63:0] rsp_q;
    logic        biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_lock_o, biu_we_o;
    logic [63:0] biu_adri_o, biu_adro_i, biu_d_o, biu_q_i;
    logic [2:0]  biu_size_o, biu_type_o, biu_prot_o;
    logic        biu_ack_i, biu_err_i;

    int checks = 0;
    int errors = 0;

    peripheral_biu_initiator #(.XLEN(64), .PLEN(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_prot(cmd_prot),
        .cmd_lock(cmd_lock), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
        .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns in the first strobe cycle.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [2:0] size,
                         input logic [63:0] data);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_size = size;
        cmd_prot = 3'b010; cmd_lock = 1'b0; cmd_data = data;
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
        chk("cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
    endtask

    // Zero-wait transfer: stb_ack and ack in the first strobe cycle.
    task automatic zero_wait(input logic we, input logic [63:0] addr, input logic [63:0] data,
                             input logic [63:0] q, input logic [63:0] exp_q);
        issue(we, addr, 3'd3, data);
        chk("zw_stb", {63'd0, biu_stb_o}, 64'd1);
        chk("zw_we", {63'd0, biu_we_o}, {63'd0, we});
        chk("zw_addr", biu_adri_o, addr);
        chk("zw_size", {61'd0, biu_size_o}, 64'd3);
        chk("zw_type", {61'd0, biu_type_o}, 64'd0);
        if (we) chk("zw_d", biu_d_o, data);
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = q;
        tick();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        chk("zw_stb_drop", {63'd0, biu_stb_o}, 64'd0);
        chk("zw_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("zw_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("zw_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("zw_rsp_q", rsp_q, exp_q);
        finish_rsp();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_lock = 1'b0;
        cmd_addr = '0; cmd_data = '0; cmd_size = '0; cmd_prot = '0;
        rsp_ready = 1'b0; biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0;
        biu_adro_i = '0; biu_q_i = '0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_stb", {63'd0, biu_stb_o}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_adri", biu_adri_o, 64'd0);
        rst = 1'b0;
        tick();

        // Write with a zero-wait responder; write data returns rsp_q = 0.
        zero_wait(1'b1, 64'h100, 64'hDEADBEEF_00000001, 64'h5555, 64'd0);

        // Read: stb_ack after 2 extra strobe cycles, ack 3 cycles later.
        issue(1'b0, 64'h100, 3'd3, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_stb_high", {63'd0, biu_stb_o}, 64'd1);
            chk("rd_addr_req", biu_adri_o, 64'h100);
            chk("rd_we_req", {63'd0, biu_we_o}, 64'd0);
            if (i == 2) biu_stb_ack_i = 1'b1;
            tick();
            biu_stb_ack_i = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            chk("rd_stb_low", {63'd0, biu_stb_o}, 64'd0);
            chk("rd_addr_wait", biu_adri_o, 64'h100);
            chk("rd_no_rsp", {63'd0, rsp_valid}, 64'd0);
            if (j == 2) begin biu_ack_i = 1'b1; biu_q_i = 64'h1234; end
            tick();
            biu_ack_i = 1'b0;
        end
        biu_q_i = 64'hFFFF;
        chk("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd_rsp_q", rsp_q, 64'h1234);
        chk("rd_rsp_err", {63'd0, rsp_err}, 64'd0);

        // Back-pressure: hold rsp_ready low with a command waiting.
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_q", rsp_q, 64'h1234);
            chk("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            chk("bp_stb", {63'd0, biu_stb_o}, 64'd0);
        end
        cmd_valid = 1'b0;
        finish_rsp();

        // Error on read: data forced to zero, not a timeout.
        issue(1'b0, 64'h200, 3'd2, 64'd0);
        biu_stb_ack_i = 1'b1; biu_err_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'hABCD;
        tick();
        biu_stb_ack_i = 1'b0; biu_err_i = 1'b0; biu_ack_i = 1'b0;
        chk("err_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("err_rsp_err", {63'd0, rsp_err}, 64'd1);
        chk("err_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        chk("err_rsp_q", rsp_q, 64'd0);
        finish_rsp();

        // Silent responder: strobe for 8 cycles, then timeout response.
        issue(1'b0, 64'h300, 3'd3, 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("to_stb_high", {63'd0, biu_stb_o}, 64'd1);
            chk("to_no_rsp", {63'd0, rsp_valid}, 64'd0);
            tick();
        end
        chk("to_stb_drop", {63'd0, biu_stb_o}, 64'd0);
        chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("to_rsp_err", {63'd0, rsp_err}, 64'd1);
        chk("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
        chk("to_rsp_q", rsp_q, 64'd0);
        biu_ack_i = 1'b1; biu_stb_ack_i = 1'b1; biu_q_i = 64'h9999;
        finish_rsp();
        tick();
        biu_ack_i = 1'b0; biu_stb_ack_i = 1'b0;
        chk("late_ack_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("late_ack_no_stb", {63'd0, biu_stb_o}, 64'd0);
        zero_wait(1'b0, 64'h308, 64'd0, 64'h77, 64'h77);

        // Reset while waiting for data.
        issue(1'b0, 64'h400, 3'd3, 64'd0);
        biu_stb_ack_i = 1'b1;
        tick();
        biu_stb_ack_i = 1'b0;
        chk("mr_wait_stb", {63'd0, biu_stb_o}, 64'd0);
        rst = 1'b1;
        tick();
        chk("mr_stb", {63'd0, biu_stb_o}, 64'd0);
        chk("mr_adri", biu_adri_o, 64'd0);
        chk("mr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mr_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        rst = 1'b0;
        biu_ack_i = 1'b1;
        tick();
        biu_ack_i = 1'b0;
        chk("mr_no_rsp", {63'd0, rsp_valid}, 64'd0);
        zero_wait(1'b0, 64'h400, 64'd0, 64'hCAFE, 64'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/peripheral_biu_initiator.md
# peripheral_biu_initiator

Single-transfer BIU bus initiator: accepts one command at a time on a valid/ready command port, drives it as a BIU strobe/address/data transaction, and returns read data or error on a valid/ready response port. It is the core-side counterpart to the BIU responders (SPRAM bridge and similar) and serves as the master BFM and lightweight DMA/debug master. A watchdog counter converts a hung transfer into an error response.

## Interface
- XLEN, 64, data width
- PLEN, 64, address width
- TIMEOUT, 1024, max cycles from strobe to completion; 0 disables the watchdog

- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&&ready
- cmd_we  input  1  1=write, 0=read
- cmd_addr  input  PLEN  transfer address
- cmd_size  input  3  transfer size (passed to biu_size_o)
- cmd_prot  input  3  protection (passed to biu_prot_o)
- cmd_lock  input  1  locked access
- cmd_data  input  XLEN  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&&ready
- rsp_q  output  XLEN  read data (0 for writes/errors)
- rsp_err  output  1  bus error or timeout
- rsp_timeout  output  1  error caused by watchdog
- biu_stb_o  output  1  strobe
- biu_stb_ack_i  input  1  strobe acknowledge
- biu_d_ack_i  input  1  data acknowledge (write data consumed)
- biu_adri_o  output  PLEN  address
- biu_adro_i  input  PLEN  returned address; unused
- biu_size_o, biu_type_o, biu_prot_o  output  3 each  size, burst type (always 3'b000 SINGLE), protection
- biu_lock_o, biu_we_o  output  1 each  lock, write enable
- biu_d_o  output  XLEN  write data
- biu_q_i  input  XLEN  read data, valid with biu_ack_i
- biu_ack_i, biu_err_i  input  1 each  transfer acknowledge / error

## Operation
- FSM states IDLE, REQ, WAIT, RESP; reset → IDLE.
- IDLE: cmd_ready=1. On accept, register addr/size/prot/lock/we/data onto biu_* outputs, clear watchdog, → REQ.
- REQ: biu_stb_o=1, all biu_* outputs stable. On biu_stb_ack_i: drop strobe next cycle; if biu_ack_i or biu_err_i same cycle → RESP, else → WAIT.
- WAIT: biu_stb_o=0, biu_adri_o/biu_d_o/controls held. On biu_ack_i or biu_err_i → RESP.
- Completion capture: rsp_q = biu_err_i ? 0 : (we ? 0 : biu_q_i); rsp_err = biu_err_i; rsp_timeout=0. ack and err together → treated as error.
- Watchdog: counts each cycle in REQ/WAIT (width $clog2(TIMEOUT+1)); when count reaches TIMEOUT-1 without completion → RESP with rsp_err=1, rsp_timeout=1, rsp_q=0, strobe dropped. Completion in the same cycle wins over timeout.
- RESP: rsp_valid=1, fields stable until rsp_ready; then → IDLE.
- biu_ack_i/biu_err_i/biu_stb_ack_i outside REQ/WAIT ignored; a late ack after timeout is discarded.
- biu_d_ack_i does not affect FSM; biu_d_o held until completion regardless.

## Timing
- Reset (rst high at edge): state IDLE; all biu_* outputs 0; rsp_valid/rsp_err/rsp_timeout 0; rsp_q 0; watchdog 0. cmd_ready is 0 while rst is high.
- Reset mid-transfer: strobe drops the next cycle, pending response lost, no rsp_valid.
- Accept at edge N → biu_stb_o high cycle N+1.
- Zero-wait responder (stb_ack and ack in N+1) → rsp_valid in N+2; with rsp_ready high, cmd_ready in N+3. Throughput: one transfer per 3 cycles max.
- Strobe held ≥1 cycle, exactly until the cycle biu_stb_ack_i is sampled.
- cmd_ready and rsp_valid never both high.

## Test plan
- Write 0xDEADBEEF_00000001 to 0x100 (size 3), responder acks in first strobe cycle → biu_stb_o high exactly 1 cycle, biu_we_o=1, rsp_valid 2 cycles after accept, rsp_err=0, rsp_q=0.
- Read 0x100 with 2-cycle stb_ack delay and 3 further cycles to ack, biu_q_i=0x1234 → strobe high 3 cycles, outputs stable, rsp_q=0x1234.
- Responder asserts biu_err_i on read → rsp_err=1, rsp_timeout=0, rsp_q=0.
- TIMEOUT=8, responder silent → strobe dropped and rsp_valid with rsp_err=1, rsp_timeout=1 at cycle 8 after strobe; later stray ack ignored, next command completes normally.
- rsp_ready low 5 cycles → rsp_valid/rsp_q stable, cmd_ready stays 0, no new strobe.
- rst pulsed in WAIT → next cycle all outputs at reset values, no response; subsequent read succeeds.
